// File: rtl/sam_pkg.sv
// Shared types for the SAM RAM arbiter: FSM states, slot owners, widths and
// the fixed-priority / alternating grant rule.
package sam_pkg;

  localparam int RAM_AW    = 16;
  localparam int REF_ROW_W = 7;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE} state_t;
  typedef enum logic [1:0] {OWN_CPU, OWN_VID, OWN_REF}     owner_t;

  // Refresh always wins; CPU and VID take turns when both ask.
  function automatic owner_t pick_owner(input logic   ref_rq,
                                        input logic   vid_rq,
                                        input logic   cpu_rq,
                                        input owner_t last_vc);
    if (ref_rq)                 return OWN_REF;
    else if (vid_rq && cpu_rq)  return (last_vc == OWN_VID) ? OWN_CPU : OWN_VID;
    else if (vid_rq)            return OWN_VID;
    else                        return OWN_CPU;
  endfunction

endpackage

// File: rtl/sam_refresh_timer.sv
// DRAM refresh pacing: interval down-counter, sticky pending flag and the
// refresh row counter that advances each time a refresh slot completes.
module sam_refresh_timer
  import sam_pkg::*;
#(
  parameter int REF_INTERVAL = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ref_done_i,
  output logic                 ref_pending_o,
  output logic [REF_ROW_W-1:0] ref_row_o
);

  localparam int            TW     = $clog2(REF_INTERVAL);
  localparam logic [TW-1:0] RELOAD = TW'(REF_INTERVAL - 1);

  logic [TW-1:0]        timer_q, timer_d;
  logic                 pend_q, pend_d;
  logic [REF_ROW_W-1:0] row_q, row_d;
  logic                 hit;

  always_comb begin
    hit     = (timer_q == '0);
    timer_d = hit ? RELOAD : timer_q - TW'(1);
    // A new interval expiring on the completing slot re-arms the request.
    pend_d  = hit | (pend_q & ~ref_done_i);
    row_d   = ref_done_i ? row_q + 1'b1 : row_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= RELOAD;
      pend_q  <= 1'b0;
      row_q   <= '0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
      row_q   <= row_d;
    end
  end

  assign ref_pending_o = pend_q;
  assign ref_row_o     = row_q;

endmodule

// File: rtl/sam_ram_arbiter.sv
// Time-slot arbiter sharing the 64Kx8 system RAM between CPU, VDG fetch and
// refresh. Refresh slots exist only when SAM_RAM_REFRESH_EN is defined.
module sam_ram_arbiter
  import sam_pkg::*;
#(
  parameter int REF_INTERVAL   = 64,
  parameter int VID_BASE_SHIFT = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [RAM_AW-1:0]    cpu_addr,
  input  logic [7:0]           cpu_wdata,
  output logic [7:0]           cpu_rdata,
  output logic                 cpu_ack,
  input  logic                 vid_req,
  input  logic                 vid_start,
  input  logic [6:0]           disp_offset,
  output logic [7:0]           vid_data,
  output logic                 vid_valid,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic                 ram_ref,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  output logic [REF_ROW_W-1:0] ref_row
);

  state_t               state_q, state_d;
  owner_t               owner_q, owner_d, last_q, last_d, gnt;
  logic [RAM_AW-1:0]    vid_addr_q, vid_addr_d;
  logic [7:0]           cpu_rdata_q, cpu_rdata_d, vid_data_q, vid_data_d;
  logic                 ref_pending;
  logic [REF_ROW_W-1:0] ref_row_w;
  logic                 cap, cpu_rq, vid_rq, ref_rq, any_rq;

  if (REF_INTERVAL < 8) begin : g_interval_check
    $error("sam_ram_arbiter: REF_INTERVAL must be at least 8");
  end

`ifdef SAM_RAM_REFRESH_EN
  logic ref_done;
  assign ref_done = (state_q == ST_CAPTURE) && (owner_q == OWN_REF);

  sam_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_refresh (
    .clk           (clk),
    .reset         (reset),
    .ref_done_i    (ref_done),
    .ref_pending_o (ref_pending),
    .ref_row_o     (ref_row_w)
  );
`else
  assign ref_pending = 1'b0;
  assign ref_row_w   = '0;
`endif

  assign ref_row = ref_row_w;

  // The slot being captured is already served, so its own request is masked.
  assign cap    = (state_q == ST_CAPTURE);
  assign cpu_rq = cpu_req     && !(cap && owner_q == OWN_CPU);
  assign vid_rq = vid_req     && !(cap && owner_q == OWN_VID);
  assign ref_rq = ref_pending && !(cap && owner_q == OWN_REF);
  assign any_rq = cpu_rq | vid_rq | ref_rq;
  assign gnt    = pick_owner(ref_rq, vid_rq, cpu_rq, last_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    vid_addr_d  = vid_addr_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_data_q;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_ref     = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    cpu_ack     = 1'b0;
    vid_valid   = 1'b0;
    cpu_rdata   = cpu_rdata_q;
    vid_data    = vid_data_q;

    case (state_q)
      ST_ISSUE: begin
        ram_cs  = 1'b1;
        state_d = ST_CAPTURE;
        case (owner_q)
          OWN_CPU: begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
          end
          OWN_VID: ram_addr = vid_addr_q;
          OWN_REF: begin
            ram_ref  = 1'b1;
            ram_addr = RAM_AW'(ref_row_w);
          end
          default: ;
        endcase
      end
      ST_CAPTURE: begin
        case (owner_q)
          OWN_CPU: begin
            cpu_ack = 1'b1;
            if (!cpu_we) begin
              cpu_rdata   = ram_rdata;
              cpu_rdata_d = ram_rdata;
            end
          end
          OWN_VID: begin
            vid_valid  = 1'b1;
            vid_data   = ram_rdata;
            vid_data_d = ram_rdata;
            vid_addr_d = vid_addr_q + 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    if (state_q != ST_ISSUE) begin
      if (any_rq) begin
        state_d = ST_ISSUE;
        owner_d = gnt;
        if (gnt != OWN_REF) last_d = gnt;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (vid_start) vid_addr_d = RAM_AW'(disp_offset) << VID_BASE_SHIFT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_VID;
      vid_addr_q  <= '0;
      cpu_rdata_q <= '0;
      vid_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      vid_addr_q  <= vid_addr_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
    end
  end

endmodule

// File: tb/tb_sam_ram_arbiter.sv
// Bench for sam_ram_arbiter: RAM model, memory/address reference model,
// directed steps followed by a randomized transaction phase.
module tb_sam_ram_arbiter;
  localparam int REF_INT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ack, vid_req, vid_start, vid_valid;
  logic [15:0] cpu_addr, ram_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, vid_data, ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic [6:0]  disp_offset, ref_row;
  logic        ram_cs, ram_we, ram_ref;

  sam_ram_arbiter #(.REF_INTERVAL(REF_INT), .VID_BASE_SHIFT(9)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_start(vid_start), .disp_offset(disp_offset),
    .vid_data(vid_data), .vid_valid(vid_valid),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_ref(ram_ref), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ref_row(ref_row)
  );

  always #5 clk = ~clk;

  logic [7:0] mem       [0:65535];
  logic [7:0] model_mem [0:65535];

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int errors = 0, checks = 0;
  int ref_cnt = 0, ref_total = 0, cyc = 0, last_ref_cyc = -1, first_ref_cyc = -1;
  bit         last_vid_m;
  logic [15:0] vaddr_m;
  logic [7:0]  last_rd_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      ref_cnt = 0; cyc = 0; last_ref_cyc = -1; first_ref_cyc = -1;
    end else begin
      cyc++;
      if (ram_cs && ram_ref) begin
`ifdef SAM_RAM_REFRESH_EN
        chk("ref_addr", ram_addr, {9'b0, 7'(ref_cnt)});
        chk("ref_row", ref_row, 7'(ref_cnt));
        chk("ref_we", ram_we, 1'b0);
        if (last_ref_cyc >= 0) chk("ref_gap_le10", (cyc - last_ref_cyc) <= 10, 1'b1);
        if (first_ref_cyc < 0) first_ref_cyc = cyc;
        last_ref_cyc = cyc;
`endif
        ref_cnt++;
        ref_total++;
      end
    end
  end

  // Leaves the caller just after a posedge with the arbiter quiet for a few cycles.
  task automatic sync_ref();
`ifdef SAM_RAM_REFRESH_EN
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ram_cs && ram_ref) seen = 1;
    end
    if (!seen) chk("sync_ref_timeout", 1'b0, 1'b1);
`endif
    @(posedge clk); #1;
  endtask

  task automatic cpu_access(input bit we, input logic [15:0] a, input logic [7:0] d,
                            input bit chk_lat);
    int cs_at = 0, ack_at = 0;
    logic [15:0] cs_addr = '0;
    logic [7:0]  cs_wd = '0, rd = '0;
    logic        cs_we = 1'b0;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int i = 1; i <= 20 && ack_at == 0; i++) begin
      @(negedge clk);
      if (ram_cs && !ram_ref && cs_at == 0) begin
        cs_at = i; cs_addr = ram_addr; cs_we = ram_we; cs_wd = ram_wdata;
      end
      if (cpu_ack) begin ack_at = i; rd = cpu_rdata; end
      @(posedge clk); #1;
    end
    cpu_req = 0;
    chk("cpu_ack_seen", ack_at != 0, 1'b1);
    if (chk_lat) begin
      chk("cpu_cs_latency", cs_at, 2);
      chk("cpu_ack_latency", ack_at, 3);
    end
    chk("cpu_ram_addr", cs_addr, a);
    chk("cpu_ram_we", cs_we, we);
    if (we) begin
      chk("cpu_ram_wdata", cs_wd, d);
      chk("cpu_rdata_hold_on_write", rd, last_rd_m);
      model_mem[a] = d;
    end else begin
      chk("cpu_rdata", rd, model_mem[a]);
      last_rd_m = model_mem[a];
    end
    last_vid_m = 0;
  endtask

  task automatic vid_fetch(input bit chk_lat);
    int cs_at = 0, v_at = 0;
    logic [15:0] cs_addr = '0;
    logic [7:0]  vd = '0;
    logic        cs_we = 1'b1;
    vid_req = 1;
    for (int i = 1; i <= 20 && v_at == 0; i++) begin
      @(negedge clk);
      if (ram_cs && !ram_ref && cs_at == 0) begin cs_at = i; cs_addr = ram_addr; cs_we = ram_we; end
      if (vid_valid) begin v_at = i; vd = vid_data; end
      @(posedge clk); #1;
    end
    vid_req = 0;
    chk("vid_valid_seen", v_at != 0, 1'b1);
    if (chk_lat) chk("vid_valid_latency", v_at, 3);
    chk("vid_ram_addr", cs_addr, vaddr_m);
    chk("vid_ram_we", cs_we, 1'b0);
    chk("vid_data", vd, model_mem[vaddr_m]);
    vaddr_m = vaddr_m + 16'd1;
    last_vid_m = 1;
  endtask

  task automatic vid_load(input logic [6:0] off);
    disp_offset = off; vid_start = 1;
    @(posedge clk); #1;
    vid_start = 0;
    vaddr_m = {off, 9'b0};
  endtask

  // Both masters hold requests; each drops after its completion once nev slots are done.
  task automatic run_both(input logic [15:0] ca, input int nev);
    bit exp_vid, drop_c = 0, drop_v = 0;
    int n = 0;
    cpu_we = 0; cpu_addr = ca; cpu_req = 1; vid_req = 1;
    exp_vid = !last_vid_m;
    for (int i = 0; i < 100 && (cpu_req || vid_req); i++) begin
      @(negedge clk);
      if (cpu_ack && cpu_req) begin
        chk("alt_order_cpu", exp_vid, 1'b0);
        chk("alt_cpu_rdata", cpu_rdata, model_mem[ca]);
        last_rd_m = model_mem[ca]; last_vid_m = 0; exp_vid = 1; n++;
        if (n >= nev) drop_c = 1;
      end
      if (vid_valid && vid_req) begin
        chk("alt_order_vid", exp_vid, 1'b1);
        chk("alt_vid_data", vid_data, model_mem[vaddr_m]);
        vaddr_m = vaddr_m + 16'd1; last_vid_m = 1; exp_vid = 0; n++;
        if (n >= nev) drop_v = 1;
      end
      @(posedge clk); #1;
      if (drop_c) cpu_req = 0;
      if (drop_v) vid_req = 0;
    end
    chk("both_done", cpu_req | vid_req, 1'b0);
    cpu_req = 0; vid_req = 0;
    chk("both_slot_count", n >= nev, 1'b1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {ram_cs, ram_we, ram_ref, cpu_ack, vid_valid}, 5'b0);
    chk({tag, "_addr"}, ram_addr, 16'h0);
    chk({tag, "_wdata"}, ram_wdata, 8'h0);
    chk({tag, "_rdata"}, {cpu_rdata, vid_data}, 16'h0);
    chk({tag, "_ref_row"}, ref_row, 7'h0);
  endtask

  initial begin
    bit ack_after;
    int op;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      model_mem[i] = mem[i];
    end
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    vid_req = 0; vid_start = 0; disp_offset = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    reset = 0;
    vaddr_m = 16'h0; last_vid_m = 1; last_rd_m = 8'h0;

    // Continuous CPU traffic straight out of reset.
    for (int i = 0; i < 6; i++) cpu_access(1'b1, 16'h8000 | 16'($urandom_range(0, 255)), 8'($urandom), 1'b0);
`ifdef SAM_RAM_REFRESH_EN
    chk("first_ref_in_window", (first_ref_cyc > 0) && (first_ref_cyc <= REF_INT + 3), 1'b1);
    chk("ref_slots_seen", ref_cnt >= 2, 1'b1);
`endif

    sync_ref();
    cpu_access(1'b1, 16'h1234, 8'h5A, 1'b1);
    sync_ref();
    cpu_access(1'b0, 16'h1234, 8'h00, 1'b1);
    chk("readback_5A", last_rd_m, 8'h5A);

    vid_load(7'h02);
    for (int i = 0; i < 3; i++) begin
      chk("vid_seq_addr", vaddr_m, 16'h0400 + 16'(i));
      sync_ref();
      vid_fetch(1'b1);
    end

    run_both(16'h1234, 8);

    vid_load(7'h7F);
    for (int i = 0; i < 511; i++) vid_fetch(1'b0);
    chk("vid_pre_wrap", vaddr_m, 16'hFFFF);
    vid_fetch(1'b0);
    vid_fetch(1'b0);

    // vid_start landing on the VID capture cycle.
    sync_ref();
    vid_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vid_start = 1; disp_offset = 7'h05;
    @(negedge clk);
    chk("coinc_valid", vid_valid, 1'b1);
    chk("coinc_data", vid_data, model_mem[vaddr_m]);
    @(posedge clk); #1;
    vid_start = 0; vid_req = 0;
    vaddr_m = 16'h0A00; last_vid_m = 1;
    vid_fetch(1'b0);

    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 4);
      a  = {8'h20, 8'($urandom_range(0, 31))};
      case (op)
        0: cpu_access(1'b1, a, 8'($urandom), 1'b0);
        1: cpu_access(1'b0, a, 8'h00, 1'b0);
        2: vid_fetch(1'b0);
        3: vid_load(7'($urandom));
        default: run_both(a, 2);
      endcase
    end

    // Reset while a CPU write is in its ISSUE cycle.
    sync_ref();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3333; cpu_wdata = ~model_mem[16'h3333];
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_issue_cs", ram_cs, 1'b1);
    #1 reset = 1;
    #1 chk_outputs_zero("mid_reset");
    @(posedge clk); #1;
    cpu_req = 0;
    @(posedge clk); #1;
    reset = 0;
    vaddr_m = 16'h0; last_vid_m = 1; last_rd_m = 8'h0;
    ack_after = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_ack) ack_after = 1;
    end
    chk("no_ack_after_abort", ack_after, 1'b0);
    @(posedge clk); #1;
    vid_fetch(1'b0);
    cpu_access(1'b0, 16'h3333, 8'h00, 1'b0);

`ifndef SAM_RAM_REFRESH_EN
    chk("no_ref_slots", ref_total, 0);
    chk("ref_row_tied", ref_row, 7'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
